div_core: RTL and testbench

Iterative radix-2 restoring integer divider, the companion to the pipelined Booth/Wallace multiplier in the CPU execute stage. It serves the DIV/DIVU class of instructions: it accepts a 32-bit dividend and divisor with a signedness flag, runs a fixed-latency multi-cycle calculation, and returns a registered quotient and remainder. A start/done handshake and a cancel input let the pipeline stall on a busy divider and abandon a divide on flush.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/div_core.sv | 107 ++++++++++
 tb/tb_div_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The true difference is below the divisor whenever it is kept, so the
  // low WIDTH bits of a modular subtract are exact.
  always_comb begin
    shifted   = {prem, dvd_bit};
    q_bit     = (shifted >= {1'b0, divisor});
    diff      = shifted[WIDTH-1:0] - divisor;
    prem_next = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider with start/done handshake and cancel.
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             cancel,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  state_t           state, state_nxt;
  logic             load;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dq, dvs, prem, prem_nxt, op1_raw;
  logic             q_bit, neg_q, neg_r, div0;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = CALC;
        load      = 1'b1;
      end
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        if (start) begin
          state_nxt = CALC;
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (cancel) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= '0;
      else if (state == CALC)
        cnt <= cnt + 1'b1;
      if (state == SIGN && !cancel) begin
        quot <= quot_fix;
        rem  <= rem_fix;
      end
    end
  end

  // dq starts as the dividend magnitude and fills with quotient bits from the right.
  always_ff @(posedge clk) begin
    if (load) begin
      dq      <= (sign_en && op1[WIDTH-1]) ? -op1 : op1;
      dvs     <= (sign_en && op2[WIDTH-1]) ? -op2 : op2;
      prem    <= '0;
      op1_raw <= op1;
      neg_q   <= sign_en & (op1[WIDTH-1] ^ op2[WIDTH-1]);
      neg_r   <= sign_en & op1[WIDTH-1];
      div0    <= (op2 == '0);
    end else if (state == CALC) begin
      dq   <= {dq[WIDTH-2:0], q_bit};
      prem <= prem_nxt;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .dvd_bit   (dq[WIDTH-1]),
    .divisor   (dvs),
    .prem_next (prem_nxt),
    .q_bit     (q_bit)
  );

  always_comb begin
    quot_fix = neg_q ? -dq : dq;
    rem_fix  = neg_r ? -prem : prem;
    if (div0) begin
      quot_fix = '1;
      rem_fix  = op1_raw;
    end
  end

endmodule

// File: tb/tb_div_core.sv
// Scoreboard bench for div_core: a driver queues expected results, a monitor checks on done.
module tb_div_core;

  logic        clk, rstn, start, cancel, sign_en;
  logic [31:0] op1, op2, quot, rem;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] held_q = '0, held_r = '0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  div_core dut (
    .clk(clk), .rstn(rstn), .start(start), .cancel(cancel), .sign_en(sign_en),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .quot(quot), .rem(rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, div0 returns all ones / dividend.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input string nm);
    exp_t e;
    op1 = a; op2 = b; sign_en = s; start = 1'b1;
    model(a, b, s, e.q, e.r);
    e.cyc = cyc + 34;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic scramble();
    start = 1'b0;
    op1 = $urandom; op2 = $urandom; sign_en = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout pending=%0d want=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, input string nm);
    @(negedge clk);
    issue(a, b, s, nm);
    @(negedge clk);
    scramble();
    drain(nm);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held_q = '0;
        held_r = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_quot"}, quot, e.q);
          chk({e.nm, "_rem"}, rem, e.r);
          chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
          held_q = e.q;
          held_r = e.r;
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    rstn = 1'b1; start = 1'b0; cancel = 1'b0; sign_en = 1'b0; op1 = '0; op2 = '0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // 100 / 7 with per-cycle busy/done profile
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0, "u100_7");
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) scramble();
      chk($sformatf("busy_c%0d", k), 32'(busy), (k <= 33) ? 32'd1 : 32'd0);
      chk($sformatf("done_c%0d", k), 32'(done), (k == 34) ? 32'd1 : 32'd0);
    end
    drain("u100_7");

    run(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
    run(32'd7, 32'hFFFF_FFFE, 1'b1, "s_7_m2");
    run(32'hFFFF_FFF9, 32'd2, 1'b0, "u_fff9_2");
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_ovf");
    run(32'h1234_5678, 32'd0, 1'b0, "u_div0");
    run(32'h1234_5678, 32'd0, 1'b1, "s_div0");
    chk("div0_held_q", held_q, 32'hFFFF_FFFF);

    // cancel mid-CALC, with an ignored start beforehand
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; sign_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op1 = 32'd5; op2 = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_idle_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_keep_quot", quot, 32'hFFFF_FFFF);
    chk("cancel_keep_rem", rem, 32'h1234_5678);
    run(32'd1000, 32'd3, 1'b0, "after_cancel");

    // start during CALC is not queued
    @(negedge clk);
    issue(32'd200, 32'd9, 1'b0, "ign_start");
    @(negedge clk);
    scramble();
    @(negedge clk);
    start = 1'b1; op1 = 32'd1; op2 = 32'd1;
    @(negedge clk);
    scramble();
    drain("ign_start");
    repeat (40) @(negedge clk);

    // back-to-back: next start in the DONE cycle
    @(negedge clk);
    issue(32'd12345, 32'd67, 1'b0, "b2b_a");
    @(negedge clk);
    scramble();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", 32'(done), 32'd1);
    issue(32'hFFFF_D8F0, 32'd77, 1'b1, "b2b_b");
    @(negedge clk);
    scramble();
    drain("b2b_b");

    // async reset mid-CALC
    run(32'd1000, 32'd3, 1'b0, "pre_rst");
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; sign_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quot", quot, 32'd0);
    chk("arst_rem", rem, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run(32'd100, 32'd7, 1'b0, "post_rst");

    // randomized operands with boundary-biased classes
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 16));
        default: ;
      endcase
      run(a, b, 1'($urandom), $sformatf("rnd%0d", n));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
